mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of both requesters and memory port.
REQ-002 Parameter DATA_W, default 32, data width; DATA_W/8 byte enables.
REQ-003 Parameter TIMEOUT, default 16, maximum number of cycles with mem_req high and no mem_ack (minimum 2).
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  instruction-fetch read request, level.
- if_addr  in  ADDR_W  fetch address.
- if_ready  out  1  one-cycle completion pulse to fetch.
- if_rdata  out  DATA_W  fetch read data, valid with if_ready.
- if_err  out  1  fetch timeout flag, valid with if_ready.
- d_req  in  1  data access request, level.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_be  in  DATA_W/8  byte enables.
- d_ready  out  1  one-cycle completion pulse to data port.
- d_rdata  out  DATA_W  data read data, valid with d_ready.
- d_err  out  1  data timeout flag, valid with d_ready.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  latched transaction fields.
- mem_ack  in  1  memory completion, single cycle.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 FSM states IDLE, OWN_I, OWN_D, DONE; all outputs registered.
REQ-006 In IDLE, a sampled request moves the FSM to OWN_I or OWN_D and latches the winner's fields into mem_* (fetch: mem_we=0, mem_be all ones, mem_wdata=0).
REQ-007 Arbitration is round-robin: if only one requester is active it wins; if both are active, the requester not granted last wins; last_owner resets to DATA, so fetch wins the first tie.
REQ-008 In OWN_I/OWN_D, mem_req is 1 and mem_* stay constant until mem_ack is sampled high.
REQ-009 On mem_ack, the FSM goes to DONE, mem_req drops to 0 the next cycle, and the owner's ready pulses for exactly one cycle.
  - rdata = mem_rdata for a read, 0 for a write.
  - err = 0.
REQ-010 DONE always returns to IDLE after one cycle.
  - Minimum req-to-ready latency is 2 cycles (ack on the first mem_req cycle).
  - Back-to-back throughput is one transaction per 3 cycles.
REQ-011 A wait counter clears on grant and increments each OWN cycle without ack. When it reaches TIMEOUT-1 with no ack, the arbiter:
  - drops mem_req;
  - enters DONE;
  - pulses the owner's ready with err=1 and rdata=0.
REQ-012 mem_ack sampled outside OWN_I/OWN_D is ignored.
REQ-013 If a requester deasserts req while it owns the port, the transaction still completes and ready still pulses; requesters must hold req and fields stable until their ready.
REQ-014 A requester still asserting req in the cycle its ready pulses is treated as a new request in the following IDLE arbitration.
REQ-015 if_ready and d_ready are never high in the same cycle; rdata/err hold their last value when ready is low.

Reset
REQ-016 rst=1 forces, asynchronously:
  - FSM = IDLE, last_owner = DATA, counter = 0;
  - mem_req, busy, if_ready, d_ready, if_err, d_err = 0;
  - all data/address outputs = 0.
REQ-017 Reset mid-transaction aborts it with no ready pulse; after reset release, arbitration restarts from IDLE on the first clock edge.

Verification
REQ-018 Single fetch: if_req, if_addr=0x00000040, memory acks 1 cycle after mem_req with 0x8C080004 -> mem_addr=0x40, mem_we=0; if_ready one cycle with if_rdata=0x8C080004, if_err=0.
REQ-019 Simultaneous requests after reset: if_req and d_req both high in the same cycle, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=0xF -> fetch is served first, then the data write (mem_we=1, mem_wdata=0xDEADBEEF); d_rdata=0.
REQ-020 Sustained contention: both requests held high for 6 transactions -> grants alternate I,D,I,D,I,D; no simultaneous ready pulses.
REQ-021 Timeout: d_req read and mem_ack never asserted, TIMEOUT=16 -> mem_req high for exactly 16 cycles, then d_ready with d_err=1 and d_rdata=0; busy returns to 0.
REQ-022 Reset mid-operation: rst pulsed while OWN_D with mem_req=1 -> mem_req=0 and busy=0 immediately with no d_ready; a subsequent if_req completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the memory arbiter.
// The arbiter takes the slave view; the requesters and the memory together take the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    output if_ready, if_rdata, if_err,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_ready, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_ready, if_rdata, if_err,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_ready, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Grant is one cycle after an IDLE request, ready is one cycle after ack; a memory port that never acks is released after TIMEOUT cycles.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  mem_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D, DONE} state_t;
  typedef enum logic {OWNER_I, OWNER_D} owner_t;

  state_t            state, state_nxt;
  owner_t            last_owner, last_owner_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic              mem_req_q, mem_req_nxt;
  logic              mem_we_q, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nxt;
  logic [BE_W-1:0]   mem_be_q, mem_be_nxt;

  logic              if_ready_q, if_ready_nxt;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_nxt;
  logic              if_err_q, if_err_nxt;
  logic              d_ready_q, d_ready_nxt;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_nxt;
  logic              d_err_q, d_err_nxt;
  logic              busy_q, busy_nxt;

  logic              grant_i, grant_d;
  logic [DATA_W-1:0] resp_data;

  // On a tie, whoever was not served last goes next.
  assign grant_i   = bus.if_req && (!bus.d_req || last_owner == OWNER_D);
  assign grant_d   = bus.d_req && !grant_i;
  assign resp_data = mem_we_q ? '0 : bus.mem_rdata;

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    cnt_nxt        = cnt;
    mem_req_nxt    = mem_req_q;
    mem_we_nxt     = mem_we_q;
    mem_addr_nxt   = mem_addr_q;
    mem_wdata_nxt  = mem_wdata_q;
    mem_be_nxt     = mem_be_q;
    if_ready_nxt   = 1'b0;
    if_rdata_nxt   = if_rdata_q;
    if_err_nxt     = if_err_q;
    d_ready_nxt    = 1'b0;
    d_rdata_nxt    = d_rdata_q;
    d_err_nxt      = d_err_q;

    case (state)
      IDLE: begin
        if (grant_i) begin
          state_nxt      = OWN_I;
          last_owner_nxt = OWNER_I;
          cnt_nxt        = '0;
          mem_req_nxt    = 1'b1;
          mem_we_nxt     = 1'b0;
          mem_addr_nxt   = bus.if_addr;
          mem_wdata_nxt  = '0;
          mem_be_nxt     = '1;
        end else if (grant_d) begin
          state_nxt      = OWN_D;
          last_owner_nxt = OWNER_D;
          cnt_nxt        = '0;
          mem_req_nxt    = 1'b1;
          mem_we_nxt     = bus.d_we;
          mem_addr_nxt   = bus.d_addr;
          mem_wdata_nxt  = bus.d_wdata;
          mem_be_nxt     = bus.d_be;
        end
      end
      OWN_I, OWN_D: begin
        // An ack on the last allowed cycle still counts as a normal completion.
        if (bus.mem_ack) begin
          state_nxt   = DONE;
          mem_req_nxt = 1'b0;
          if (state == OWN_I) begin
            if_ready_nxt = 1'b1;
            if_rdata_nxt = resp_data;
            if_err_nxt   = 1'b0;
          end else begin
            d_ready_nxt  = 1'b1;
            d_rdata_nxt  = resp_data;
            d_err_nxt    = 1'b0;
          end
        end else if (cnt == CNT_MAX) begin
          state_nxt   = DONE;
          mem_req_nxt = 1'b0;
          if (state == OWN_I) begin
            if_ready_nxt = 1'b1;
            if_rdata_nxt = '0;
            if_err_nxt   = 1'b1;
          end else begin
            d_ready_nxt  = 1'b1;
            d_rdata_nxt  = '0;
            d_err_nxt    = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_owner  <= OWNER_D;
      cnt         <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      d_ready_q   <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_owner  <= last_owner_nxt;
      cnt         <= cnt_nxt;
      mem_req_q   <= mem_req_nxt;
      mem_we_q    <= mem_we_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
      mem_be_q    <= mem_be_nxt;
      if_ready_q  <= if_ready_nxt;
      if_rdata_q  <= if_rdata_nxt;
      if_err_q    <= if_err_nxt;
      d_ready_q   <= d_ready_nxt;
      d_rdata_q   <= d_rdata_nxt;
      d_err_q     <= d_err_nxt;
      busy_q      <= busy_nxt;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_err    = if_err_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_err     = d_err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Random fetch/data traffic against a transaction-schedule model of the arbiter.
// Each grant gets a memory delay chosen here; mem_req window, ready cycle and response follow arithmetically.
module tb_mem_arbiter;
  localparam int T = 16;
  localparam int NCYC = 4000;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp, input int cyc);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // transaction in flight: owner 0 = fetch, 1 = data
  bit          act;
  int          own, g, d, dur, rc, idle_from, last;
  bit          t_err;
  logic        t_we;
  logic [31:0] t_addr, t_wdata, ack_dat;
  logic [3:0]  t_be;
  // expected held response values
  logic [31:0] e_if_rdata, e_d_rdata;
  logic        e_if_err, e_d_err;
  // requester agents
  bit          ia_on, da_on;
  logic [31:0] ia_addr, da_addr, da_wdata;
  logic        da_we;
  logic [3:0]  da_be;
  int          n_resets;

  task automatic model_clear();
    act = 0; idle_from = 0; last = 1;
    e_if_rdata = '0; e_d_rdata = '0; e_if_err = 1'b0; e_d_err = 1'b0;
    ia_on = 0; da_on = 0;
  endtask

  task automatic drive_inputs();
    bus.if_req  = ia_on;
    bus.if_addr = ia_addr;
    bus.d_req   = da_on;
    bus.d_we    = da_we;
    bus.d_addr  = da_addr;
    bus.d_wdata = da_wdata;
    bus.d_be    = da_be;
  endtask

  task automatic check_all_zero(input string tag, input int c);
    chk({tag, "_mem_req"}, {63'd0, bus.mem_req}, 64'd0, c);
    chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd0, c);
    chk({tag, "_if_ready"}, {63'd0, bus.if_ready}, 64'd0, c);
    chk({tag, "_d_ready"}, {63'd0, bus.d_ready}, 64'd0, c);
    chk({tag, "_errs"}, {62'd0, bus.if_err, bus.d_err}, 64'd0, c);
    chk({tag, "_mem_addr"}, {32'd0, bus.mem_addr}, 64'd0, c);
    chk({tag, "_mem_wdata"}, {32'd0, bus.mem_wdata}, 64'd0, c);
    chk({tag, "_mem_we_be"}, {59'd0, bus.mem_we, bus.mem_be}, 64'd0, c);
    chk({tag, "_if_rdata"}, {32'd0, bus.if_rdata}, 64'd0, c);
    chk({tag, "_d_rdata"}, {32'd0, bus.d_rdata}, 64'd0, c);
  endtask

  initial begin
    int  c;
    bit  e_mreq, e_busy, e_ir, e_dr, just_reset;
    rst = 1'b1;
    model_clear();
    ia_addr = '0; da_addr = '0; da_wdata = '0; da_we = 1'b0; da_be = '0;
    n_resets = 0;
    drive_inputs();
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset", -1);
    // both requesters arrive together straight out of reset: fetch must win the first tie
    rst = 1'b0;
    ia_on = 1; ia_addr = 32'h0000_0040;
    da_on = 1; da_we = 1'b1; da_addr = 32'h0000_0100; da_wdata = 32'hDEAD_BEEF; da_be = 4'hF;
    c = 0;

    while (c < NCYC) begin
      just_reset = 0;
      e_mreq = act && c >= g && c <= g + dur;
      e_busy = act && c >= g && c <= rc;
      e_ir   = act && own == 0 && c == rc;
      e_dr   = act && own == 1 && c == rc;
      if (e_ir) begin
        e_if_rdata = t_err ? 32'd0 : ack_dat;
        e_if_err   = t_err;
      end
      if (e_dr) begin
        e_d_rdata = (t_err || t_we) ? 32'd0 : ack_dat;
        e_d_err   = t_err;
      end
      chk("mem_req", {63'd0, bus.mem_req}, {63'd0, e_mreq}, c);
      chk("busy", {63'd0, bus.busy}, {63'd0, e_busy}, c);
      chk("if_ready", {63'd0, bus.if_ready}, {63'd0, e_ir}, c);
      chk("d_ready", {63'd0, bus.d_ready}, {63'd0, e_dr}, c);
      chk("one_ready", {63'd0, bus.if_ready & bus.d_ready}, 64'd0, c);
      chk("if_rdata", {32'd0, bus.if_rdata}, {32'd0, e_if_rdata}, c);
      chk("if_err", {63'd0, bus.if_err}, {63'd0, e_if_err}, c);
      chk("d_rdata", {32'd0, bus.d_rdata}, {32'd0, e_d_rdata}, c);
      chk("d_err", {63'd0, bus.d_err}, {63'd0, e_d_err}, c);
      if (e_mreq) begin
        chk("mem_addr", {32'd0, bus.mem_addr}, {32'd0, t_addr}, c);
        chk("mem_wdata", {32'd0, bus.mem_wdata}, {32'd0, t_wdata}, c);
        chk("mem_we_be", {59'd0, bus.mem_we, bus.mem_be}, {59'd0, t_we, t_be}, c);
      end

      // asynchronous reset while the data side owns the port and is still waiting
      if (act && own == 1 && c == g + 1 && d >= 3 && d < T && n_resets < 3 && ($urandom % 3) == 0) begin
        n_resets++;
        bus.mem_ack = 1'b0;
        #1 rst = 1'b1;
        #1 check_all_zero("midrst", c);
        @(negedge clk);
        c++;
        rst = 1'b0;
        model_clear();
        just_reset = 1;
      end

      if (act && c == rc) begin
        act = 0;
        idle_from = c + 1;
        if (own == 0) begin
          ia_on = ($urandom % 2) == 0;
          ia_addr = $urandom;
        end else begin
          da_on = ($urandom % 2) == 0;
          da_we = $urandom % 2; da_addr = $urandom; da_wdata = $urandom; da_be = 4'($urandom);
        end
      end

      if (!just_reset) begin
        if (!ia_on && !(act && own == 0) && ($urandom % 3) == 0) begin
          ia_on = 1; ia_addr = $urandom;
        end
        if (!da_on && !(act && own == 1) && ($urandom % 3) == 0) begin
          da_on = 1; da_we = $urandom % 2; da_addr = $urandom; da_wdata = $urandom; da_be = 4'($urandom);
        end
        // an owner may let go of req early; its transaction must still finish
        if (ia_on && act && own == 0 && c >= g && ($urandom % 8) == 0) ia_on = 0;
        if (da_on && act && own == 1 && c >= g && ($urandom % 8) == 0) da_on = 0;
      end

      if (!act && c >= idle_from && (ia_on || da_on)) begin
        if (ia_on && da_on) own = (last == 1) ? 0 : 1;
        else                own = ia_on ? 0 : 1;
        last = own;
        act  = 1;
        g    = c + 1;
        if (own == 0) begin
          t_we = 1'b0; t_addr = ia_addr; t_wdata = '0; t_be = 4'hF;
        end else begin
          t_we = da_we; t_addr = da_addr; t_wdata = da_wdata; t_be = da_be;
        end
        case ($urandom % 8)
          0:       d = T + 3;
          1:       d = T - 1;
          default: d = int'($urandom % 4);
        endcase
        dur   = (d < T) ? d : T - 1;
        rc    = g + dur + 1;
        t_err = (d >= T);
      end

      bus.mem_rdata = $urandom;
      if (act && d < T && c == g + d) begin
        bus.mem_ack = 1'b1;
        ack_dat = bus.mem_rdata;
      end else if (!(act && c >= g && c <= g + dur)) begin
        bus.mem_ack = ($urandom % 6) == 0;
      end else begin
        bus.mem_ack = 1'b0;
      end

      drive_inputs();
      @(negedge clk);
      c++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
